pipe_reg_bank: RTL

Parametrised bank of pipelined registers: DEPTH stages, each WIDTH bits wide, with a valid bit per stage. It carries stall (enable), flush and occupancy tracking, plus a serial scan chain through the data flops for BIST observation and loading. It is the generic building block for the delay lines in the PMBIST address/data/compare paths, and replaces hand-chained single-bit flip-flops.

---
 rtl/pipe_reg_bank.sv | 66 ++++++
 1 files changed

// File: rtl/pipe_reg_bank.sv
// Parametrised pipelined register bank with per-stage valid bits, stall, flush,
// occupancy count and a serial scan chain threaded through the data flops.
module pipe_reg_bank #(
   parameter int               WIDTH   = 8,
   parameter int               DEPTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0,
   localparam int              OCC_W   = $clog2(DEPTH + 1),
   localparam int              CHAIN_W = WIDTH * DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             flush,
   input  logic             v_in,
   input  logic [WIDTH-1:0] d_in,
   output logic             v_out,
   output logic [WIDTH-1:0] q_out,
   output logic [OCC_W-1:0] occ,
   input  logic             scan_en,
   input  logic             scan_in,
   output logic             scan_out
);

   logic [WIDTH-1:0]   r_data [DEPTH];
   logic [DEPTH-1:0]   r_vld;
   logic [CHAIN_W-1:0] w_chain;
   logic [CHAIN_W:0]   w_chain_sh;
   logic [OCC_W-1:0]   w_occ;

   // Stage 0 occupies the low bits, so a left shift walks bits toward scan_out.
   for (genvar s = 0; s < DEPTH; s++) begin : g_flat
      assign w_chain[s*WIDTH +: WIDTH] = r_data[s];
   end
   assign w_chain_sh = {w_chain, scan_in};

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < DEPTH; s++) r_data[s] <= RST_VAL;
         r_vld <= '0;
      end else if (scan_en) begin
         for (int s = 0; s < DEPTH; s++) r_data[s] <= w_chain_sh[s*WIDTH +: WIDTH];
      end else begin
         if (en) begin
            r_data[0] <= d_in;
            for (int s = 1; s < DEPTH; s++) r_data[s] <= r_data[s-1];
         end
         if (flush) begin
            r_vld <= '0;
         end else if (en) begin
            r_vld[0] <= v_in;
            for (int s = 1; s < DEPTH; s++) r_vld[s] <= r_vld[s-1];
         end
      end
   end

   always_comb begin
      w_occ = '0;
      for (int s = 0; s < DEPTH; s++) w_occ = w_occ + OCC_W'(r_vld[s]);
   end

   assign q_out    = r_data[DEPTH-1];
   assign v_out    = r_vld[DEPTH-1];
   assign scan_out = r_data[DEPTH-1][WIDTH-1];
   assign occ      = w_occ;

endmodule
